// File: rtl/tile_edge_walker.sv
// rtl/tile_edge_walker.sv - walks one screen tile with incremental edge functions and emits covered fragments
module tile_edge_walker #(
  parameter int FX_TOTAL_BITS     = 16,
  parameter int FX_FRAC_BITS      = 4,
  parameter int COLOR_BITS        = 4,
  parameter int TILE_W            = 16,
  parameter int TILE_H            = 16,
  parameter int TILE_COLUMNS_BITS = 6,
  parameter int TILE_ROWS_BITS    = 5,
  parameter int CULL_MODE         = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           vld_in,
  output logic                           rdy_in,
  input  logic [FX_TOTAL_BITS-1:0]       v0_x,
  input  logic [FX_TOTAL_BITS-1:0]       v0_y,
  input  logic [FX_TOTAL_BITS-1:0]       v1_x,
  input  logic [FX_TOTAL_BITS-1:0]       v1_y,
  input  logic [FX_TOTAL_BITS-1:0]       v2_x,
  input  logic [FX_TOTAL_BITS-1:0]       v2_y,
  input  logic [COLOR_BITS-1:0]          color,
  input  logic [TILE_COLUMNS_BITS-1:0]   tile_x,
  input  logic [TILE_ROWS_BITS-1:0]      tile_y,
  input  logic                           rdy_out,
  output logic                           vld_out,
  output logic [FX_TOTAL_BITS-1:0]       pixel_out_x,
  output logic [FX_TOTAL_BITS-1:0]       pixel_out_y,
  output logic [COLOR_BITS-1:0]          color_out,
  output logic [2*FX_TOTAL_BITS+2:0]     edge_out_0,
  output logic [2*FX_TOTAL_BITS+2:0]     edge_out_1,
  output logic [2*FX_TOTAL_BITS+2:0]     edge_out_2,
  output logic                           tri_done
);

  localparam int EDGE_BITS = 2*FX_TOTAL_BITS+3;
  localparam int LOG2W     = $clog2(TILE_W);
  localparam int LOG2H     = $clog2(TILE_H);
  localparam bit DOUBLE_SIDED = (CULL_MODE != 0);

  typedef enum logic [1:0] {IDLE, SETUP, WALK, FINISH} state_t;
  state_t state_q, state_d;

  logic signed [FX_TOTAL_BITS-1:0] vx_q [3];
  logic signed [FX_TOTAL_BITS-1:0] vy_q [3];
  logic [COLOR_BITS-1:0]           color_q;
  logic [TILE_COLUMNS_BITS-1:0]    tile_x_q;
  logic [TILE_ROWS_BITS-1:0]       tile_y_q;

  logic signed [EDGE_BITS-1:0] dx_q [3], dy_q [3];
  logic signed [EDGE_BITS-1:0] e_q [3], e_d [3];
  logic [LOG2W-1:0] px_q, px_d;
  logic [LOG2H-1:0] py_q, py_d;
  logic area_pos_q, area_pos_d, area_neg_q, area_neg_d;
  logic tri_done_q;

  logic signed [EDGE_BITS-1:0] vxe [3], vye [3], dx_s [3], dy_s [3], e_init [3];
  logic signed [EDGE_BITS-1:0] org_x, org_y, area;
  logic all_ge, all_le, covered, last_px, row_end, advance;

  // Setup arithmetic: everything widened to EDGE_BITS so products never overflow.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      vxe[i] = EDGE_BITS'(vx_q[i]);
      vye[i] = EDGE_BITS'(vy_q[i]);
    end
    dx_s[0] = vxe[1] - vxe[0];
    dx_s[1] = vxe[2] - vxe[1];
    dx_s[2] = vxe[0] - vxe[2];
    dy_s[0] = vye[1] - vye[0];
    dy_s[1] = vye[2] - vye[1];
    dy_s[2] = vye[0] - vye[2];
    org_x = EDGE_BITS'({tile_x_q, {(LOG2W+FX_FRAC_BITS){1'b0}}});
    org_y = EDGE_BITS'({tile_y_q, {(LOG2H+FX_FRAC_BITS){1'b0}}});
    for (int i = 0; i < 3; i++) begin
      e_init[i] = (org_x - vxe[i]) * dy_s[i] - (org_y - vye[i]) * dx_s[i];
    end
    area = (vxe[2] - vxe[0]) * dy_s[0] - (vye[2] - vye[0]) * dx_s[0];
  end

  always_comb begin
    all_ge = 1'b1;
    all_le = 1'b1;
    for (int i = 0; i < 3; i++) begin
      all_ge = all_ge & ~e_q[i][EDGE_BITS-1];
      all_le = all_le & (e_q[i][EDGE_BITS-1] | (e_q[i] == '0));
    end
    covered = (area_pos_q & all_ge) | (DOUBLE_SIDED & area_neg_q & all_le);
    row_end = (px_q == LOG2W'(TILE_W-1));
    last_px = row_end & (py_q == LOG2H'(TILE_H-1));
    advance = (state_q == WALK) & (~covered | rdy_out);
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    area_pos_d = area_pos_q;
    area_neg_d = area_neg_q;
    for (int i = 0; i < 3; i++) e_d[i] = e_q[i];
    case (state_q)
      IDLE: if (vld_in) state_d = SETUP;
      SETUP: begin
        for (int i = 0; i < 3; i++) e_d[i] = e_init[i];
        px_d       = '0;
        py_d       = '0;
        area_pos_d = (area > 0);
        area_neg_d = (area < 0);
        if (area == 0 || (area < 0 && !DOUBLE_SIDED)) state_d = FINISH;
        else                                          state_d = WALK;
      end
      WALK: if (advance) begin
        if (last_px) begin
          state_d = FINISH;
        end else if (row_end) begin
          // Undo the TILE_W-1 x-steps of this row and move down one pixel.
          px_d = '0;
          py_d = py_q + 1'b1;
          for (int i = 0; i < 3; i++)
            e_d[i] = e_q[i] - (((dy_q[i] <<< LOG2W) - dy_q[i] + dx_q[i]) <<< FX_FRAC_BITS);
        end else begin
          px_d = px_q + 1'b1;
          for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + (dy_q[i] <<< FX_FRAC_BITS);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      color_q    <= '0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      px_q       <= '0;
      py_q       <= '0;
      area_pos_q <= 1'b0;
      area_neg_q <= 1'b0;
      tri_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        dx_q[i] <= '0;
        dy_q[i] <= '0;
        e_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      area_pos_q <= area_pos_d;
      area_neg_q <= area_neg_d;
      tri_done_q <= (state_q == FINISH);
      for (int i = 0; i < 3; i++) e_q[i] <= e_d[i];
      if (state_q == IDLE && vld_in) begin
        vx_q[0]  <= v0_x;
        vy_q[0]  <= v0_y;
        vx_q[1]  <= v1_x;
        vy_q[1]  <= v1_y;
        vx_q[2]  <= v2_x;
        vy_q[2]  <= v2_y;
        color_q  <= color;
        tile_x_q <= tile_x;
        tile_y_q <= tile_y;
      end
      if (state_q == SETUP) begin
        for (int i = 0; i < 3; i++) begin
          dx_q[i] <= dx_s[i];
          dy_q[i] <= dy_s[i];
        end
      end
    end
  end

  // Fragment fields are zero whenever no fragment is presented.
  assign rdy_in      = (state_q == IDLE);
  assign vld_out     = (state_q == WALK) & covered;
  assign pixel_out_x = vld_out ? FX_TOTAL_BITS'({tile_x_q, px_q, {FX_FRAC_BITS{1'b0}}}) : '0;
  assign pixel_out_y = vld_out ? FX_TOTAL_BITS'({tile_y_q, py_q, {FX_FRAC_BITS{1'b0}}}) : '0;
  assign color_out   = vld_out ? color_q : '0;
  assign edge_out_0  = vld_out ? e_q[0] : '0;
  assign edge_out_1  = vld_out ? e_q[1] : '0;
  assign edge_out_2  = vld_out ? e_q[2] : '0;
  assign tri_done    = tri_done_q;

endmodule

// File: tb/tb_tile_edge_walker.sv
// tb/tb_tile_edge_walker.sv - scoreboard bench for tile_edge_walker, single- and double-sided instances
module tb_tile_edge_walker;
  localparam int EB = 35;

  logic clk = 1'b0;
  logic rst_n, vld_in, rdy_out;
  logic [15:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic [3:0]  color;
  logic [5:0]  tile_x;
  logic [4:0]  tile_y;

  logic rdy_in0, vld_out0, td0, rdy_in1, vld_out1, td1;
  logic [15:0] px0, py0, px1, py1;
  logic [3:0]  col0, col1;
  logic signed [EB-1:0] e00, e01, e02, e10, e11, e12;

  always #5 clk = ~clk;

  tile_edge_walker #(.CULL_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in0),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .color(color), .tile_x(tile_x), .tile_y(tile_y), .rdy_out(rdy_out),
    .vld_out(vld_out0), .pixel_out_x(px0), .pixel_out_y(py0), .color_out(col0),
    .edge_out_0(e00), .edge_out_1(e01), .edge_out_2(e02), .tri_done(td0));

  tile_edge_walker #(.CULL_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in1),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .color(color), .tile_x(tile_x), .tile_y(tile_y), .rdy_out(rdy_out),
    .vld_out(vld_out1), .pixel_out_x(px1), .pixel_out_y(py1), .color_out(col1),
    .edge_out_0(e10), .edge_out_1(e11), .edge_out_2(e12), .tri_done(td1));

  typedef struct {longint x; longint y; longint c; longint e0; longint e1; longint e2;} frag_t;
  frag_t q0[$], q1[$];
  frag_t f0, f1;

  int n_vec = 0, n_err = 0;
  int cnt0, cnt1;
  longint first0x, first0y, last0x, last0y;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected fragments from direct per-pixel edge evaluation.
  task automatic gen(input int ax[3], input int ay[3], input int tx, input int ty, input int col);
    longint vx[3], vy[3], dx[3], dy[3], e[3], area, X, Y;
    bit ge, le;
    frag_t f;
    for (int i = 0; i < 3; i++) begin
      vx[i] = ax[i] * 16;
      vy[i] = ay[i] * 16;
    end
    for (int i = 0; i < 3; i++) begin
      dx[i] = vx[(i+1)%3] - vx[i];
      dy[i] = vy[(i+1)%3] - vy[i];
    end
    area = (vx[2] - vx[0]) * dy[0] - (vy[2] - vy[0]) * dx[0];
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        X = (tx * 16 + x) * 16;
        Y = (ty * 16 + y) * 16;
        ge = 1; le = 1;
        for (int i = 0; i < 3; i++) begin
          e[i] = (X - vx[i]) * dy[i] - (Y - vy[i]) * dx[i];
          if (e[i] < 0) ge = 0;
          if (e[i] > 0) le = 0;
        end
        f = '{X, Y, col, e[0], e[1], e[2]};
        if (area > 0 && ge) begin
          q0.push_back(f);
          q1.push_back(f);
        end else if (area < 0 && le) begin
          q1.push_back(f);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld_out0 && rdy_out) begin
      if (q0.size() == 0) chk("dut0 unexpected fragment", 1, 0);
      else begin
        f0 = q0.pop_front();
        chk("dut0 x", px0, f0.x);
        chk("dut0 y", py0, f0.y);
        chk("dut0 color", col0, f0.c);
        chk("dut0 e0", e00, f0.e0);
        chk("dut0 e1", e01, f0.e1);
        chk("dut0 e2", e02, f0.e2);
      end
      if (cnt0 == 0) begin first0x = px0; first0y = py0; end
      last0x = px0; last0y = py0;
      cnt0++;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld_out1 && rdy_out) begin
      if (q1.size() == 0) chk("dut1 unexpected fragment", 1, 0);
      else begin
        f1 = q1.pop_front();
        chk("dut1 x", px1, f1.x);
        chk("dut1 y", py1, f1.y);
        chk("dut1 color", col1, f1.c);
        chk("dut1 e0", e10, f1.e0);
        chk("dut1 e1", e11, f1.e1);
        chk("dut1 e2", e12, f1.e2);
      end
      cnt1++;
    end
  end

  task automatic run_tri(input string name, input int ax[3], input int ay[3], input int tx, input int ty,
                         input int col, input int exp_c0, input int exp_c1, input int exp_l0, input int exp_l1,
                         input bit stall, input bit abort, input int fx, input int fy, input int lx, input int ly);
    int k, w, lat0, lat1, held, tdc0;
    bit d0, d1, aborted, bad;
    gen(ax, ay, tx, ty, col);
    cnt0 = 0; cnt1 = 0; d0 = 0; d1 = 0; lat0 = 0; lat1 = 0; held = 0; tdc0 = 0; aborted = 0;
    @(negedge clk);
    rdy_out = !stall;
    v0_x = 16'(ax[0] * 16); v0_y = 16'(ay[0] * 16);
    v1_x = 16'(ax[1] * 16); v1_y = 16'(ay[1] * 16);
    v2_x = 16'(ax[2] * 16); v2_y = 16'(ay[2] * 16);
    color = 4'(col); tile_x = 6'(tx); tile_y = 5'(ty);
    vld_in = 1'b1;
    w = 0;
    while (!rdy_in0 && w < 20) begin @(negedge clk); w++; end
    chk({name, " accept wait bound"}, (w < 20), 1);
    chk({name, " rdy_in1 idle"}, rdy_in1, 1);
    @(posedge clk); #1;
    vld_in = 1'b0;
    v0_x = 16'h7ff0; v1_y = 16'h0130; color = 4'hf; tile_x = 6'h3f;
    k = 0;
    while (!(d0 && d1) && !aborted && k < 400) begin
      @(posedge clk); k++; #1;
      if (td0) tdc0++;
      if (td0 && !d0) begin d0 = 1; lat0 = k + 1; chk({name, " rdy_in with tri_done"}, rdy_in0, 1); end
      if (td1 && !d1) begin d1 = 1; lat1 = k + 1; end
      if (stall && vld_out0 && !rdy_out) begin
        held++;
        chk({name, " held x"}, px0, 16);
        chk({name, " held y"}, py0, 16);
        if (held == 4) rdy_out = 1'b1;
      end
      if (abort && cnt0 == 5) begin
        rst_n = 1'b0;
        #1;
        chk({name, " vld_out in reset"}, vld_out0, 0);
        chk({name, " pixel_x in reset"}, px0, 0);
        chk({name, " tri_done in reset"}, td0, 0);
        aborted = 1;
      end
    end
    if (abort) begin
      chk({name, " abort reached"}, aborted, 1);
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (td0 || td1 || vld_out0 || vld_out1) bad = 1;
      end
      chk({name, " quiet after abort"}, bad, 0);
      chk({name, " rdy_in after abort"}, rdy_in0, 1);
      q0.delete(); q1.delete();
    end else begin
      chk({name, " tri_done0 latency"}, lat0, exp_l0);
      chk({name, " tri_done1 latency"}, lat1, exp_l1);
      @(posedge clk); #1;
      if (td0) tdc0++;
      chk({name, " tri_done0 single pulse"}, tdc0, 1);
      chk({name, " dut0 count"}, cnt0, exp_c0);
      chk({name, " dut1 count"}, cnt1, exp_c1);
      chk({name, " dut0 leftover"}, q0.size(), 0);
      chk({name, " dut1 leftover"}, q1.size(), 0);
      if (exp_c0 > 0) begin
        chk({name, " first x"}, first0x, fx * 16);
        chk({name, " first y"}, first0y, fy * 16);
        chk({name, " last x"}, last0x, lx * 16);
        chk({name, " last y"}, last0y, ly * 16);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; vld_in = 1'b0; rdy_out = 1'b1;
    v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
    color = '0; tile_x = '0; tile_y = '0;
    cnt0 = 0; cnt1 = 0;
    repeat (3) @(negedge clk);
    chk("reset vld_out", vld_out0, 0);
    chk("reset tri_done", td0, 0);
    chk("reset pixel_x", px0, 0);
    chk("reset edge0", e00, 0);
    chk("reset color", col0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset rdy_in", rdy_in0, 1);

    run_tri("basic",     '{1, 1, 5},    '{1, 5, 1}, 0, 0, 4, 15, 15, 259, 259, 0, 0, 1, 1, 1, 5);
    run_tri("shifted",   '{17, 17, 21}, '{1, 5, 1}, 1, 0, 4, 15, 15, 259, 259, 0, 0, 17, 1, 17, 5);
    run_tri("reversed",  '{1, 5, 1},    '{1, 1, 5}, 0, 0, 6, 0, 15, 3, 259, 0, 0, 0, 0, 0, 0);
    run_tri("collinear", '{0, 2, 4},    '{0, 2, 4}, 0, 0, 2, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    run_tri("stall",     '{1, 1, 5},    '{1, 5, 1}, 0, 0, 4, 15, 15, 262, 262, 1, 0, 1, 1, 1, 5);
    run_tri("abort",     '{1, 1, 5},    '{1, 5, 1}, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_tri("after",     '{1, 1, 5},    '{1, 5, 1}, 0, 0, 9, 15, 15, 259, 259, 0, 0, 1, 1, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tile_edge_walker.md
TILE_EDGE_WALKER -- requirements
Module: tile_edge_walker

Interface
REQ-001 Parameter FX_TOTAL_BITS, default 16, signed fixed-point coordinate width.
REQ-002 Parameter FX_FRAC_BITS, default 4, fraction bits of coordinates.
REQ-003 Parameter COLOR_BITS, default 4, color width.
REQ-004 Parameter TILE_W, default 16, tile width in pixels (power of two, >=2).
REQ-005 Parameter TILE_H, default 16, tile height in pixels (power of two, >=2).
REQ-006 Parameter TILE_COLUMNS_BITS, default 6; TILE_ROWS_BITS, default 5; tile index widths.
REQ-007 Parameter CULL_MODE, default 0: 0 = accept positive-area triangles only, 1 = double-sided.
REQ-008 Derived EDGE_BITS = 2*FX_TOTAL_BITS+3.
REQ-009 clk  in  1  single clock; all state on rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 vld_in  in  1  triangle valid.
REQ-012 rdy_in  out  1  block can accept a triangle.
REQ-013 v0_x, v0_y, v1_x, v1_y, v2_x, v2_y  in  FX_TOTAL_BITS each  signed screen-space vertices.
REQ-014 color  in  COLOR_BITS; tile_x  in  TILE_COLUMNS_BITS; tile_y  in  TILE_ROWS_BITS.
REQ-015 rdy_out  in  1  downstream accepts fragment.
REQ-016 vld_out  out  1  fragment valid.
REQ-017 pixel_out_x, pixel_out_y  out  FX_TOTAL_BITS each  absolute pixel position, integer<<FX_FRAC_BITS.
REQ-018 color_out  out  COLOR_BITS  triangle color.
REQ-019 edge_out_0, edge_out_1, edge_out_2  out  EDGE_BITS each  signed edge values at fragment.
REQ-020 tri_done  out  1  one-cycle pulse when a triangle's walk ends.

Function
REQ-021 Handshake transfers when valid and ready both high at a rising edge; rdy_in SHALL be high only in IDLE.
REQ-022 States: IDLE, SETUP, WALK, FINISH.
REQ-023 IDLE + vld_in -> register vertices, color, tile; go SETUP.
REQ-024 SETUP (1 cycle): dx_i = v(i+1).x - vi.x, dy_i = v(i+1).y - vi.y (indices mod 3), full-width signed, no truncation.
REQ-025 SETUP: origin p = (tile_x*TILE_W, tile_y*TILE_H)<<FX_FRAC_BITS; e_i = (p.x-vi.x)*dy_i - (p.y-vi.y)*dx_i; area = e_0 evaluated at v2.
REQ-026 SETUP: area==0, or area<0 with CULL_MODE==0 -> FINISH, zero fragments.
REQ-027 WALK visits all TILE_W*TILE_H pixels row-major, one pixel per cycle when not stalled; first pixel evaluated the cycle after SETUP.
REQ-028 Step x: e_i += dy_i<<FX_FRAC_BITS; row end: e_i -= (TILE_W-1)*(dy_i<<FX_FRAC_BITS) + (dx_i<<FX_FRAC_BITS); incremental only, no per-pixel multiply.
REQ-029 Covered: area>0 and all e_i>=0, or area<0 and all e_i<=0 (CULL_MODE==1 only).
REQ-030 Uncovered pixels SHALL produce no output and cost one cycle.
REQ-031 Covered pixel -> vld_out high with pixel, color, edge values; while vld_out && !rdy_out walker and all outputs SHALL hold stable.
REQ-032 After last pixel's fragment transfers (or last pixel uncovered) -> FINISH; FINISH pulses tri_done one cycle, vld_out low, -> IDLE.
REQ-033 vld_in outside IDLE SHALL be ignored; inputs sampled only on acceptance.
REQ-034 Worst case latency acceptance to tri_done = TILE_W*TILE_H+3 cycles with rdy_out held high.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, rdy_in=1 once released state is IDLE, vld_out=0, tri_done=0, pixel/color/edge outputs=0.
REQ-036 Reset mid-WALK SHALL abort the triangle with no further fragments and no tri_done pulse.

Verification
REQ-037 Tile (0,0), v=(1,1),(1,5),(5,1), color 4, rdy_out=1 -> 15 fragments, first (1,1), last (1,5), all satisfy x,y>=1, x+y<=6, then tri_done.
REQ-038 Same triangle shifted +16 in x, tile (1,0) -> 15 fragments, first (17,1), last (17,5).
REQ-039 Reversed winding (1,1),(5,1),(1,5): CULL_MODE=0 -> 0 fragments, tri_done 3 cycles after acceptance; CULL_MODE=1 -> same 15 fragments as REQ-037.
REQ-040 Collinear (0,0),(2,2),(4,4) -> 0 fragments, tri_done, rdy_in high within 4 cycles of acceptance.
REQ-041 REQ-037 with rdy_out low 3 cycles at first fragment -> (1,1) held stable 4 cycles, total count still 15, no duplicates.
REQ-042 Assert rst_n low after 5th fragment of REQ-037 -> vld_out low immediately, no tri_done; next triangle processes normally.
